// File: rtl/spmv_sched_pkg.sv
// Shared types for the SpMV kernel scheduler: per-kernel FSM states, the
// completion record and the saturating cycle-counter step.
package spmv_sched_pkg;

   localparam int CYC_W      = 64;
   localparam int REC_ID_W   = 32;
   localparam int REC_KIDX_W = 16;

   typedef enum logic [1:0] {
      K_IDLE   = 2'd0,
      K_LAUNCH = 2'd1,
      K_RUN    = 2'd2,
      K_REPORT = 2'd3
   } kstate_t;

   // Fields are sized for the widest supported tag/index; the top slices them down.
   typedef struct packed {
      logic [REC_ID_W-1:0]   id;
      logic [REC_KIDX_W-1:0] kernel;
      logic [CYC_W-1:0]      cycles;
   } cpl_rec_t;

   function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
      return (&v) ? v : v + CYC_W'(1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i, wrapping
// around; returns a one-hot grant plus its index.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      // First pass covers [ptr, N-1]; second pass supplies the wrap-around.
      for (int k = 0; k < N; k++) begin
         if (!any_o && req_i[k] && (k >= int'(ptr_i))) begin
            any_o    = 1'b1;
            gnt_o[k] = 1'b1;
            idx_o    = IDX_W'(k);
         end
      end
      for (int k = 0; k < N; k++) begin
         if (!any_o && req_i[k]) begin
            any_o    = 1'b1;
            gnt_o[k] = 1'b1;
            idx_o    = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/spmv_kernel_scheduler.sv
// Dispatches SpMV jobs round-robin onto NUM_KERNEL kernels, times each job and
// returns one completion record per job through a round-robin completion port.
module spmv_kernel_scheduler
   import spmv_sched_pkg::*;
#(
   parameter int NUM_KERNEL = 4,
   parameter int ID_W       = 8,
   parameter int KIDX_W     = (NUM_KERNEL > 1) ? $clog2(NUM_KERNEL) : 1
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    enable,
   input  logic [NUM_KERNEL-1:0]   kernel_mask,
   input  logic                    job_valid,
   output logic                    job_ready,
   input  logic [31:0]             job_row,
   input  logic [31:0]             job_nnz,
   input  logic [ID_W-1:0]         job_id,
   output logic [NUM_KERNEL-1:0]   k_start,
   output logic [32*NUM_KERNEL-1:0] k_row,
   output logic [32*NUM_KERNEL-1:0] k_nnz,
   input  logic [NUM_KERNEL-1:0]   k_done,
   output logic                    cpl_valid,
   input  logic                    cpl_ready,
   output logic [ID_W-1:0]         cpl_id,
   output logic [KIDX_W-1:0]       cpl_kernel,
   output logic [CYC_W-1:0]        cpl_cycles,
   output logic                    busy
);

   logic [NUM_KERNEL-1:0] idle_w, rpt_w, elig_w;
   logic [NUM_KERNEL-1:0] dgnt_w, carb_gnt_w, cgnt_w, acc_sel_w, rel_w;
   logic [KIDX_W-1:0]     didx_w, carb_idx_w, cidx_w;
   logic                  dany_w, cany_w, accept_w, hs_w;

   logic [KIDX_W-1:0]     dptr_q, dptr_d, cptr_q, cptr_d;
   logic                  lock_q, lock_d;
   logic [KIDX_W-1:0]     lock_idx_q, lock_idx_d;
   logic [NUM_KERNEL-1:0] lock_gnt_q, lock_gnt_d;

   logic [ID_W-1:0]       id_w  [NUM_KERNEL];
   logic [CYC_W-1:0]      cyc_w [NUM_KERNEL];
   cpl_rec_t              rec_w;
   logic                  unused_rec_hi;

   function automatic logic [KIDX_W-1:0] ptr_inc(input logic [KIDX_W-1:0] p);
      return (p == KIDX_W'(NUM_KERNEL - 1)) ? '0 : p + KIDX_W'(1);
   endfunction

   // Dispatch side
   assign elig_w    = idle_w & kernel_mask;
   assign job_ready = aresetn & enable & dany_w;
   assign accept_w  = job_valid & job_ready;
   assign acc_sel_w = {NUM_KERNEL{accept_w}} & dgnt_w;

   rr_arbiter #(.N(NUM_KERNEL), .IDX_W(KIDX_W)) u_disp_arb (
      .req_i (elig_w),
      .ptr_i (dptr_q),
      .gnt_o (dgnt_w),
      .idx_o (didx_w),
      .any_o (dany_w)
   );

   // Completion side; a stalled grant is held so cpl_* cannot change under the consumer.
   rr_arbiter #(.N(NUM_KERNEL), .IDX_W(KIDX_W)) u_cpl_arb (
      .req_i (rpt_w),
      .ptr_i (cptr_q),
      .gnt_o (carb_gnt_w),
      .idx_o (carb_idx_w),
      .any_o (cany_w)
   );

   assign cgnt_w    = lock_q ? lock_gnt_q : carb_gnt_w;
   assign cidx_w    = lock_q ? lock_idx_q : carb_idx_w;
   assign cpl_valid = cany_w;
   assign hs_w      = cpl_valid & cpl_ready;
   assign rel_w     = {NUM_KERNEL{hs_w}} & cgnt_w;
   assign busy      = |(~idle_w);

   always_comb begin
      rec_w = '0;
      for (int k = 0; k < NUM_KERNEL; k++) begin
         if (cgnt_w[k]) begin
            rec_w.id[ID_W-1:0] = id_w[k];
            rec_w.kernel       = REC_KIDX_W'(k);
            rec_w.cycles       = cyc_w[k];
         end
      end
   end

   assign cpl_id        = rec_w.id[ID_W-1:0];
   assign cpl_kernel    = rec_w.kernel[KIDX_W-1:0];
   assign cpl_cycles    = rec_w.cycles;
   assign unused_rec_hi = ^{rec_w.id, rec_w.kernel};

   always_comb begin
      dptr_d     = accept_w ? ptr_inc(didx_w) : dptr_q;
      cptr_d     = hs_w ? ptr_inc(cidx_w) : cptr_q;
      lock_d     = cpl_valid & ~cpl_ready;
      lock_idx_d = cidx_w;
      lock_gnt_d = cgnt_w;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         dptr_q     <= '0;
         cptr_q     <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         lock_gnt_q <= '0;
      end else begin
         dptr_q     <= dptr_d;
         cptr_q     <= cptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         lock_gnt_q <= lock_gnt_d;
      end
   end

   for (genvar i = 0; i < NUM_KERNEL; i++) begin : g_kernel
      kstate_t          st_q, st_d;
      logic [31:0]      row_q, row_d, nnz_q, nnz_d;
      logic [ID_W-1:0]  id_q, id_d;
      logic [CYC_W-1:0] cnt_q, cnt_d, cyc_q, cyc_d;

      always_comb begin
         st_d  = st_q;
         row_d = row_q;
         nnz_d = nnz_q;
         id_d  = id_q;
         cnt_d = cnt_q;
         cyc_d = cyc_q;
         unique case (st_q)
            K_IDLE: begin
               if (acc_sel_w[i]) begin
                  st_d  = K_LAUNCH;
                  row_d = job_row;
                  nnz_d = job_nnz;
                  id_d  = job_id;
                  cnt_d = '0;
               end
            end
            K_LAUNCH: begin
               cnt_d = sat_inc(cnt_q);
               st_d  = K_RUN;
            end
            K_RUN: begin
               cnt_d = sat_inc(cnt_q);
               // Count includes the LAUNCH cycle and the done cycle itself.
               if (k_done[i]) begin
                  cyc_d = sat_inc(cnt_q);
                  st_d  = K_REPORT;
               end
            end
            K_REPORT: begin
               if (rel_w[i]) st_d = K_IDLE;
            end
            default: st_d = K_IDLE;
         endcase
      end

      always_ff @(posedge aclk) begin
         if (!aresetn) begin
            st_q  <= K_IDLE;
            row_q <= '0;
            nnz_q <= '0;
            id_q  <= '0;
            cnt_q <= '0;
            cyc_q <= '0;
         end else begin
            st_q  <= st_d;
            row_q <= row_d;
            nnz_q <= nnz_d;
            id_q  <= id_d;
            cnt_q <= cnt_d;
            cyc_q <= cyc_d;
         end
      end

      assign idle_w[i]           = (st_q == K_IDLE);
      assign rpt_w[i]            = (st_q == K_REPORT);
      assign k_start[i]          = (st_q == K_LAUNCH);
      assign k_row[32*i +: 32]   = row_q;
      assign k_nnz[32*i +: 32]   = nnz_q;
      assign id_w[i]             = id_q;
      assign cyc_w[i]            = cyc_q;
   end

endmodule

// File: tb/tb_spmv_kernel_scheduler.sv
// Scoreboard bench for spmv_kernel_scheduler with a behavioural kernel array model.
module tb_spmv_kernel_scheduler;

   localparam int NK  = 4;
   localparam int IDW = 8;
   localparam int KW  = 2;

   logic              aclk = 1'b0;
   logic              aresetn, enable, job_valid, job_ready, cpl_valid, cpl_ready, busy;
   logic [NK-1:0]     kernel_mask, k_start, k_done;
   logic [31:0]       job_row, job_nnz;
   logic [IDW-1:0]    job_id, cpl_id;
   logic [32*NK-1:0]  k_row, k_nnz;
   logic [KW-1:0]     cpl_kernel;
   logic [63:0]       cpl_cycles;

   typedef struct { int kern; logic [31:0] row; logic [31:0] nnz; int delay; int cyc; } disp_t;
   typedef struct { int id; int kern; longint cycles; } exp_t;

   disp_t dq[$];
   exp_t  sb[$];
   int    hs_cyc[$];
   int    rem[NK];
   int    starts[NK];
   int    cyc = 0;
   int    n_chk = 0;
   int    n_pass = 0;

   spmv_kernel_scheduler #(.NUM_KERNEL(NK), .ID_W(IDW), .KIDX_W(KW)) dut (
      .aclk(aclk), .aresetn(aresetn), .enable(enable), .kernel_mask(kernel_mask),
      .job_valid(job_valid), .job_ready(job_ready), .job_row(job_row), .job_nnz(job_nnz),
      .job_id(job_id), .k_start(k_start), .k_row(k_row), .k_nnz(k_nnz), .k_done(k_done),
      .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_id(cpl_id),
      .cpl_kernel(cpl_kernel), .cpl_cycles(cpl_cycles), .busy(busy)
   );

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Kernel array model: checks each start against the dispatch expectation, then
   // pulses k_done 'delay' cycles after the start cycle.
   always @(negedge aclk) begin : kmodel
      disp_t e;
      if (!aresetn) begin
         k_done = '0;
         for (int k = 0; k < NK; k++) rem[k] = 0;
      end else begin
         for (int k = 0; k < NK; k++) begin
            k_done[k] = 1'b0;
            if (rem[k] > 0) begin
               rem[k]--;
               if (rem[k] == 0) k_done[k] = 1'b1;
            end
            if (k_start[k]) starts[k]++;
         end
         if (k_start != '0) begin
            if (dq.size() == 0) check("kstart_unexpected", 64'(k_start), 64'd0);
            else begin
               e = dq.pop_front();
               check("kstart_vec", 64'(k_start), 64'(1) << e.kern);
               check("kstart_cycle", 64'(cyc), 64'(e.cyc + 1));
               check("k_row", 64'(k_row[32*e.kern +: 32]), 64'(e.row));
               check("k_nnz", 64'(k_nnz[32*e.kern +: 32]), 64'(e.nnz));
               rem[e.kern] = e.delay;
            end
         end
      end
   end

   // Completion monitor: scoreboard pop on handshake, stability during stalls.
   logic           prev_stall = 1'b0;
   logic [IDW-1:0] prev_id;
   logic [KW-1:0]  prev_k;
   logic [63:0]    prev_cyc;

   always @(negedge aclk) begin : cmon
      int idx;
      if (!aresetn) prev_stall = 1'b0;
      else begin
         if (prev_stall) begin
            check("stall_valid", 64'(cpl_valid), 64'd1);
            check("stall_id", 64'(cpl_id), 64'(prev_id));
            check("stall_kernel", 64'(cpl_kernel), 64'(prev_k));
            check("stall_cycles", cpl_cycles, prev_cyc);
         end
         if (cpl_valid && cpl_ready) begin
            idx = -1;
            foreach (sb[j]) if (sb[j].id == int'(cpl_id)) idx = j;
            check("cpl_known_id", 64'(idx >= 0), 64'd1);
            if (idx >= 0) begin
               check("cpl_kernel", 64'(cpl_kernel), 64'(sb[idx].kern));
               check("cpl_cycles", cpl_cycles, 64'(sb[idx].cycles));
               sb.delete(idx);
            end
            hs_cyc.push_back(cyc);
         end
         prev_stall = cpl_valid && !cpl_ready;
         prev_id    = cpl_id;
         prev_k     = cpl_kernel;
         prev_cyc   = cpl_cycles;
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic send_job(input logic [IDW-1:0] id, input logic [31:0] row, input logic [31:0] nnz,
                           input int delay, input int kexp, output int acc);
      int    n;
      disp_t d;
      exp_t  x;
      job_valid = 1'b1;
      job_id    = id;
      job_row   = row;
      job_nnz   = nnz;
      n = 0;
      @(negedge aclk);
      while (!job_ready && n < 400) begin
         @(negedge aclk);
         n++;
      end
      check("dispatch_wait", 64'(n < 400), 64'd1);
      acc = cyc;
      if (n < 400) begin
         d.kern = kexp; d.row = row; d.nnz = nnz; d.delay = delay; d.cyc = cyc;
         dq.push_back(d);
         x.id = int'(id); x.kern = kexp; x.cycles = longint'(delay + 1);
         sb.push_back(x);
         tick();
      end else begin
         job_valid = 1'b0;
         tick();
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge aclk);
      while ((busy || sb.size() != 0) && n < 600) begin
         @(negedge aclk);
         n++;
      end
      check("idle_wait", 64'(n < 600), 64'd1);
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_k_start"}, 64'(k_start), 64'd0);
      check({tag, "_k_row"}, 64'(|k_row), 64'd0);
      check({tag, "_k_nnz"}, 64'(|k_nnz), 64'd0);
      check({tag, "_cpl_valid"}, 64'(cpl_valid), 64'd0);
      check({tag, "_cpl_id"}, 64'(cpl_id), 64'd0);
      check({tag, "_cpl_kernel"}, 64'(cpl_kernel), 64'd0);
      check({tag, "_cpl_cycles"}, cpl_cycles, 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic do_reset();
      aresetn = 1'b0; job_valid = 1'b0; cpl_ready = 1'b1; enable = 1'b1; kernel_mask = '1;
      tick();
      @(negedge aclk);
      check("rst_job_ready", 64'(job_ready), 64'd0);
      check_reset_outputs("rst");
      tick();
      aresetn = 1'b1;
      dq.delete(); sb.delete(); hs_cyc.delete();
      for (int k = 0; k < NK; k++) starts[k] = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int a[5];
      int n, hs;
      aresetn = 1'b0; enable = 1'b1; kernel_mask = '1; job_valid = 1'b0;
      job_row = '0; job_nnz = '0; job_id = '0; cpl_ready = 1'b1;
      for (int k = 0; k < NK; k++) starts[k] = 0;

      // Single job, done 20 cycles after start -> cycles 21.
      do_reset();
      send_job(8'h05, 32'd16, 32'd100, 20, 0, a[0]);
      job_valid = 1'b0;
      wait_idle();

      // Five back-to-back jobs.
      do_reset();
      for (int j = 0; j < 4; j++) send_job(IDW'(16 + j), 32'(8 + j), 32'(40 + j), 30, j, a[j]);
      @(negedge aclk);
      check("t2_full_ready", 64'(job_ready), 64'd0);
      tick();
      for (int j = 1; j < 4; j++) check("t2_consecutive", 64'(a[j]), 64'(a[j-1] + 1));
      send_job(8'h14, 32'd3, 32'd9, 5, 0, a[4]);
      job_valid = 1'b0;
      check("t2_redispatch_cycle", 64'(a[4]), 64'((hs_cyc.size() > 0) ? hs_cyc[0] + 1 : -1));
      wait_idle();

      // Mask 1010: alternate kernels 1 and 3.
      do_reset();
      kernel_mask = 4'b1010;
      send_job(8'h20, 32'd1, 32'd2, 3, 1, a[0]);
      send_job(8'h21, 32'd3, 32'd4, 3, 3, a[1]);
      send_job(8'h22, 32'd5, 32'd6, 3, 1, a[2]);
      send_job(8'h23, 32'd7, 32'd8, 3, 3, a[3]);
      job_valid = 1'b0;
      wait_idle();
      check("t3_k0_starts", 64'(starts[0]), 64'd0);
      check("t3_k2_starts", 64'(starts[2]), 64'd0);
      check("t3_k1_starts", 64'(starts[1]), 64'd2);
      check("t3_k3_starts", 64'(starts[3]), 64'd2);
      kernel_mask = '1;

      // Simultaneous done on kernels 1 and 2 with a 5-cycle completion stall.
      do_reset();
      send_job(8'h30, 32'd1, 32'd1, 60, 0, a[0]);
      send_job(8'h31, 32'd2, 32'd2, 9, 1, a[1]);
      send_job(8'h32, 32'd3, 32'd3, 8, 2, a[2]);
      job_valid = 1'b0;
      cpl_ready = 1'b0;
      n = 0;
      @(negedge aclk);
      while (!cpl_valid && n < 100) begin
         @(negedge aclk);
         n++;
      end
      check("t4_valid_wait", 64'(n < 100), 64'd1);
      for (int s = 0; s < 5; s++) begin
         check("t4_hold_kernel", 64'(cpl_kernel), 64'd1);
         check("t4_hold_id", 64'(cpl_id), 64'h31);
         if (s < 4) @(negedge aclk);
      end
      tick();
      cpl_ready = 1'b1;
      tick();
      @(negedge aclk);
      check("t4_next_valid", 64'(cpl_valid), 64'd1);
      check("t4_next_kernel", 64'(cpl_kernel), 64'd2);
      check("t4_next_id", 64'(cpl_id), 64'h32);
      wait_idle();

      // Enable dropped with two jobs in flight.
      do_reset();
      send_job(8'h40, 32'd11, 32'd12, 12, 0, a[0]);
      send_job(8'h41, 32'd13, 32'd14, 15, 1, a[1]);
      job_valid = 1'b0;
      enable = 1'b0;
      @(negedge aclk);
      check("t5_ready_low", 64'(job_ready), 64'd0);
      hs = 0; n = 0;
      while (hs < 2 && n < 200) begin
         @(negedge aclk);
         if (cpl_valid && cpl_ready) hs++;
         n++;
      end
      check("t5_hs_count", 64'(hs), 64'd2);
      check("t5_busy_at_last_hs", 64'(busy), 64'd1);
      @(negedge aclk);
      check("t5_busy_after", 64'(busy), 64'd0);
      check("t5_ready_still_low", 64'(job_ready), 64'd0);
      tick();
      enable = 1'b1;

      // One-cycle reset while kernel 0 runs.
      do_reset();
      send_job(8'h60, 32'd7, 32'd70, 30, 0, a[0]);
      job_valid = 1'b0;
      repeat (5) tick();
      aresetn = 1'b0;
      @(negedge aclk);
      check("t6_rst_ready", 64'(job_ready), 64'd0);
      tick();
      aresetn = 1'b1;
      dq.delete(); sb.delete();
      @(negedge aclk);
      check_reset_outputs("t6");
      n = 0;
      repeat (40) begin
         @(negedge aclk);
         if (cpl_valid) n++;
      end
      check("t6_no_cpl", 64'(n), 64'd0);
      tick();
      send_job(8'h61, 32'd5, 32'd50, 4, 0, a[0]);
      job_valid = 1'b0;
      wait_idle();

      check("sb_empty", 64'(sb.size()), 64'd0);
      check("dq_empty", 64'(dq.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/spmv_kernel_scheduler.md
# spmv_kernel_scheduler

Dispatches SpMV jobs from a single job stream onto `NUM_KERNEL` parallel SpMV kernels. It drives each kernel's start pulse and row/nnz configuration, measures per-job execution cycles, and returns one completion record per job. It sits between the host-facing job queue and the kernel array, in place of direct host register pokes of per-kernel ctrl/row/nnz.

## Interface
Parameters:
- `NUM_KERNEL`, 4: number of kernels; must be at least 1.
- `ID_W`, 8: job tag width.
- `KIDX_W`, `$clog2(NUM_KERNEL)` (minimum 1): kernel index width.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: reset, synchronous, active-low.
- `enable` in 1: allows new dispatch.
- `kernel_mask` in NUM_KERNEL: 1 = kernel may receive jobs.
- `job_valid` in 1 / `job_ready` out 1: job handshake.
- `job_row` in 32: number of matrix rows.
- `job_nnz` in 32: number of non-zeros.
- `job_id` in ID_W: job tag.
- `k_start` out NUM_KERNEL: one-cycle start pulse per kernel.
- `k_row`, `k_nnz` out 32*NUM_KERNEL each: per-kernel config; kernel i occupies bits [32i+31:32i].
- `k_done` in NUM_KERNEL: one-cycle completion pulse per kernel.
- `cpl_valid` out 1 / `cpl_ready` in 1: completion handshake.
- `cpl_id` out ID_W: tag of the completed job.
- `cpl_kernel` out KIDX_W: kernel that ran the job.
- `cpl_cycles` out 64: job execution cycles.
- `busy` out 1: any kernel not IDLE.

## Operation
- Each kernel has its own FSM with states IDLE → LAUNCH → RUN → REPORT → IDLE.
- Eligible kernel: IDLE and `kernel_mask[i]`=1.
- `job_ready` = `enable` AND (at least one eligible kernel). It is combinational from state, mask and enable, and never depends on `job_valid`.
- Dispatch pointer `dptr`:
  - Round-robin selection: the first eligible kernel at or after `dptr`, with wrap-around.
  - On accept, `dptr` ← selected index + 1, wrapping modulo NUM_KERNEL.
- On accept:
  - The selected kernel goes to LAUNCH.
  - `k_row[i]`, `k_nnz[i]`, the stored id, and cycle counter = 0 are latched.
  - `k_row`/`k_nnz` hold until the kernel re-enters LAUNCH.
- LAUNCH:
  - `k_start[i]`=1 for exactly one cycle.
  - Counter increments.
  - Next state is RUN.
  - `k_done[i]` is ignored in LAUNCH.
- RUN:
  - Counter increments every cycle.
  - On `k_done[i]`: `cycles[i]` ← counter + 1, then go to REPORT.
  - `cycles` counts the LAUNCH cycle through the done cycle inclusive.
  - The counter saturates at 2^64−1.
- REPORT: waits for the completion arbiter.
  - The arbiter grants round-robin among REPORT kernels, starting from `cptr`.
  - The grant is locked while `cpl_valid` && !`cpl_ready`; `cpl_*` stay stable during the stall.
  - On handshake, the granted kernel goes to IDLE and `cptr` ← grant + 1.
- `k_done` while in IDLE or REPORT is ignored. Verification flags it as a kernel protocol error.
- `enable` low or mask clear stops new dispatch only; in-flight jobs complete and report normally.
- Zero row/nnz values are dispatched unchanged.

## Timing
- Reset values:
  - All FSMs IDLE; `dptr` = `cptr` = 0.
  - `k_start` = 0, `k_row` = `k_nnz` = 0.
  - `cpl_valid` = 0, `cpl_id` = `cpl_kernel` = `cpl_cycles` = 0.
  - `busy` = 0, `job_ready` = 0 during reset.
- Accept at cycle T → `k_start` high at T+1.
- `k_done` at cycle D → `cpl_valid` at D+1 at the earliest.
- A kernel freed by a completion handshake at cycle C is eligible at C+1. There is no same-cycle re-dispatch.
- At most one job is accepted and at most one completion is emitted per cycle. Dispatch and completion may occur in the same cycle on different kernels.
- Reset mid-job: all state is discarded and no completion is emitted. The kernel array is reset by the same `aresetn`.

## Structure
- Package `spmv_sched_pkg`:
  - FSM state enum `kstate_t`.
  - Completion record struct (id, kernel, cycles).
  - Localparam `CYC_W` = 64.
- Sub-module `rr_arbiter` (parameterised N; request vector, pointer, one-hot grant) is instantiated twice: once for dispatch, once for completion.
- Per-kernel FSM, counter and latches are built with a generate loop in the top module.

## Test plan
- Single job: row=16, nnz=100, id=0x5. Kernel 0 asserts `k_done` 20 cycles after `k_start`. Required: `k_start[0]` pulses at T+1, `k_row[0]`=16, `k_nnz[0]`=100, completion id=5, kernel=0, cycles=21.
- Five back-to-back jobs, all kernels idle, mask=4'hF. Required: dispatch to kernels 0,1,2,3 on consecutive cycles, then `job_ready`=0 until the first completion handshake.
- `kernel_mask`=4'b1010. Required: jobs go alternately to kernels 1 and 3; kernels 0 and 2 never see `k_start`.
- Kernels 1 and 2 assert `k_done` in the same cycle, and `cpl_ready`=0 for 5 cycles. Required: the kernel 1 record holds stable for 5 cycles, then the kernel 2 record follows on the next cycle.
- `enable` dropped while 2 jobs run. Required: `job_ready`=0; both completions are still emitted; `busy` falls after the last handshake.
- `aresetn` low for 1 cycle while kernel 0 is in RUN. Required: all outputs return to reset values, no completion is emitted, and the next job dispatches to kernel 0.
